// File: rtl/hilo_mdu_if.sv
// EX-stage to multiply/divide unit bundle: decoder controls and operands in,
// stall, HI/LO read data and architectural HI/LO out.
interface hilo_mdu_if;
  logic        ex_valid;
  logic        ex_mult;
  logic        ex_div;
  logic        ex_mdsign;
  logic [1:0]  ex_hilowen;
  logic [1:0]  ex_hiloren;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic        ex_go;
  logic        flush;
  logic        mdu_stall;
  logic [31:0] hilo_rdata;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output ex_valid, ex_mult, ex_div, ex_mdsign, ex_hilowen, ex_hiloren,
           ex_a, ex_b, ex_go, flush,
    input  mdu_stall, hilo_rdata, hi, lo
  );

  modport slave (
    input  ex_valid, ex_mult, ex_div, ex_mdsign, ex_hilowen, ex_hiloren,
           ex_a, ex_b, ex_go, flush,
    output mdu_stall, hilo_rdata, hi, lo
  );
endinterface

// File: rtl/hilo_mdu.sv
// Multiply/divide unit with HI/LO registers: 1-cycle multiply, 32-cycle
// restoring divide, results committed only when the owner leaves EX unflushed.
module hilo_mdu (
  input  logic       clk,
  input  logic       resetn,
  hilo_mdu_if.slave  bus
);
  localparam int unsigned W    = 32;
  localparam int unsigned CNTW = 5;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [W-1:0]    opa, opb, rem;
  logic            sign, neg_q, neg_r;
  logic [2*W-1:0]  res;
  logic [W-1:0]    hi_r, lo_r;

  logic            start, mt_wr;
  logic [W-1:0]    abs_a, abs_b;
  logic [W:0]      rem_sh;
  logic [W+1:0]    trial;
  logic            ge;
  logic [W-1:0]    rem_next, q_next, q_fix, r_fix;
  logic [2*W-1:0]  mul_prod;

  // Start is gated by reset so a held instruction cannot stall during reset.
  assign start = resetn && (state == IDLE) && bus.ex_valid &&
                 (bus.ex_mult || bus.ex_div) && !bus.flush;
  assign mt_wr = (state == IDLE) && bus.ex_valid && bus.ex_go && !bus.flush &&
                 !bus.ex_mult && !bus.ex_div && (bus.ex_hilowen != 2'b00);

  assign abs_a = (bus.ex_mdsign && bus.ex_a[W-1]) ? W'(-bus.ex_a) : bus.ex_a;
  assign abs_b = (bus.ex_mdsign && bus.ex_b[W-1]) ? W'(-bus.ex_b) : bus.ex_b;

  // One restoring step; the extra guard bit keeps the borrow unambiguous.
  always_comb begin
    rem_sh   = {rem, opa[W-1]};
    trial    = {1'b0, rem_sh} - {2'b00, opb};
    ge       = !trial[W+1];
    rem_next = ge ? trial[W-1:0] : rem_sh[W-1:0];
    q_next   = {opa[W-2:0], ge};
    q_fix    = neg_q ? W'(-q_next) : q_next;
    r_fix    = neg_r ? W'(-rem_next) : rem_next;
  end

  assign mul_prod = {{W{sign & opa[W-1]}}, opa} * {{W{sign & opb[W-1]}}, opb};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      opa   <= '0;
      opb   <= '0;
      rem   <= '0;
      sign  <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      res   <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= bus.ex_mult ? bus.ex_a : abs_a;
            opb   <= bus.ex_mult ? bus.ex_b : abs_b;
            sign  <= bus.ex_mdsign;
            neg_q <= bus.ex_mdsign & (bus.ex_a[W-1] ^ bus.ex_b[W-1]);
            neg_r <= bus.ex_mdsign & bus.ex_a[W-1];
            rem   <= '0;
            cnt   <= '0;
            state <= bus.ex_mult ? MUL : DIV;
          end else if (mt_wr) begin
            if (bus.ex_hilowen[0]) lo_r <= bus.ex_a;
            if (bus.ex_hilowen[1]) hi_r <= bus.ex_a;
          end
        end
        MUL: begin
          res   <= mul_prod;
          state <= DONE;
        end
        DIV: begin
          opa <= q_next;
          rem <= rem_next;
          cnt <= cnt + CNTW'(1);
          if (cnt == CNTW'(W - 1)) begin
            res   <= {r_fix, q_fix};
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.ex_go) begin
            hi_r  <= res[2*W-1:W];
            lo_r  <= res[W-1:0];
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mdu_stall  = start || (state == MUL) || (state == DIV);
  assign bus.hilo_rdata = bus.ex_hiloren[1] ? hi_r : lo_r;
  assign bus.hi         = hi_r;
  assign bus.lo         = lo_r;
endmodule

// File: tb/tb_hilo_mdu.sv
// Bench for hilo_mdu: directed scenarios plus randomized mult/div against an
// arithmetic reference model of HI/LO.
module tb_hilo_mdu;
  logic clk;
  logic resetn;
  int   checks;
  int   failures;
  logic [31:0] exp_hi, exp_lo;

  hilo_mdu_if bus ();
  hilo_mdu dut (.clk(clk), .resetn(resetn), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = 64'(sa * sb);
    end else begin
      p = 64'(a) * 64'(b);
    end
    return p;
  endfunction

  // {HI, LO} = {remainder, quotient}; remainder follows the dividend's sign.
  function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, (sg && a[31]) ? 32'd1 : 32'hFFFF_FFFF};
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic idle_inputs();
    bus.ex_valid   = 1'b0;
    bus.ex_mult    = 1'b0;
    bus.ex_div     = 1'b0;
    bus.ex_mdsign  = 1'b0;
    bus.ex_hilowen = 2'b00;
    bus.ex_hiloren = 2'b00;
    bus.ex_a       = 32'd0;
    bus.ex_b       = 32'd0;
    bus.ex_go      = 1'b0;
    bus.flush      = 1'b0;
  endtask

  // Issues one mult/div with ex_go held, counts stall cycles, returns #1 after commit.
  task automatic run_op(input logic wait_edge, input logic is_div, input logic sg,
                        input logic [31:0] a, input logic [31:0] b, output int stalls);
    if (wait_edge) begin @(posedge clk); #1; end
    bus.ex_valid = 1'b1; bus.ex_mult = !is_div; bus.ex_div = is_div;
    bus.ex_mdsign = sg; bus.ex_hilowen = 2'b11; bus.ex_a = a; bus.ex_b = b;
    bus.ex_go = 1'b1; bus.flush = 1'b0;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.mdu_stall) stalls++;
      else break;
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic do_mt(input logic [1:0] wen, input logic [31:0] a);
    @(posedge clk); #1;
    bus.ex_valid = 1'b1; bus.ex_go = 1'b1; bus.ex_hilowen = wen; bus.ex_a = a;
    @(posedge clk); #1;
    idle_inputs();
    if (wen[0]) exp_lo = a;
    if (wen[1]) exp_hi = a;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.mdu_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", bus.mdu_stall); end
    checks++; if (bus.hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
    checks++; if (bus.lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
    resetn = 1'b1;
    exp_hi = 32'd0; exp_lo = 32'd0;
  endtask

  task automatic test_mult();
    int st;
    run_op(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3, st);
    checks++; if (st !== 2) begin failures++; $display("FAIL mult_stall got=%0d exp=2", st); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFA) begin failures++; $display("FAIL mult_res got=%h_%h exp=ffffffff_fffffffa", bus.hi, bus.lo); end
    run_op(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd3, st);
    checks++; if (st !== 2) begin failures++; $display("FAIL multu_stall got=%0d exp=2", st); end
    checks++; if (bus.hi !== 32'h0000_0002 || bus.lo !== 32'hFFFF_FFFA) begin failures++; $display("FAIL multu_res got=%h_%h exp=00000002_fffffffa", bus.hi, bus.lo); end
    exp_hi = bus.hi; exp_lo = bus.lo;
  endtask

  task automatic test_div();
    int st;
    run_op(1'b1, 1'b1, 1'b0, 32'd100, 32'd7, st);
    checks++; if (st !== 33) begin failures++; $display("FAIL divu_stall got=%0d exp=33", st); end
    checks++; if (bus.hi !== 32'd2 || bus.lo !== 32'd14) begin failures++; $display("FAIL divu_res got=%h_%h exp=00000002_0000000e", bus.hi, bus.lo); end
    run_op(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, st);
    checks++; if (st !== 33) begin failures++; $display("FAIL div_stall got=%0d exp=33", st); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_res got=%h_%h exp=ffffffff_fffffffd", bus.hi, bus.lo); end
    run_op(1'b1, 1'b1, 1'b0, 32'h1234_5678, 32'd0, st);
    checks++; if (st !== 33) begin failures++; $display("FAIL div0_stall got=%0d exp=33", st); end
    checks++; if (bus.hi !== 32'h1234_5678 || bus.lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div0_res got=%h_%h exp=12345678_ffffffff", bus.hi, bus.lo); end
    exp_hi = 32'h1234_5678; exp_lo = 32'hFFFF_FFFF;
  endtask

  task automatic test_flush();
    int st;
    do_mt(2'b10, 32'h11);
    do_mt(2'b01, 32'h22);
    @(posedge clk); #1;
    bus.ex_valid = 1'b1; bus.ex_div = 1'b1; bus.ex_mdsign = 1'b1; bus.ex_hilowen = 2'b11;
    bus.ex_a = 32'd1000; bus.ex_b = 32'd9; bus.ex_go = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (bus.mdu_stall !== 1'b1) begin failures++; $display("FAIL flush_pre_stall got=%0b exp=1", bus.mdu_stall); end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.mdu_stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%0b exp=0", bus.mdu_stall); end
    checks++; if (bus.hi !== 32'h11 || bus.lo !== 32'h22) begin failures++; $display("FAIL flush_hilo got=%h_%h exp=00000011_00000022", bus.hi, bus.lo); end
    run_op(1'b1, 1'b0, 1'b1, 32'd2, 32'd3, st);
    checks++; if (st !== 2) begin failures++; $display("FAIL flush_mult_stall got=%0d exp=2", st); end
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd6) begin failures++; $display("FAIL flush_mult_res got=%h_%h exp=00000000_00000006", bus.hi, bus.lo); end
    exp_hi = 32'd0; exp_lo = 32'd6;
  endtask

  task automatic test_mthi_mfhi();
    do_mt(2'b10, 32'hA);
    bus.ex_valid = 1'b1; bus.ex_hiloren = 2'b10;
    @(negedge clk);
    checks++; if (bus.hilo_rdata !== 32'h0000_000A) begin failures++; $display("FAIL mfhi got=%h exp=0000000a", bus.hilo_rdata); end
    checks++; if (bus.mdu_stall !== 1'b0) begin failures++; $display("FAIL mfhi_stall got=%0b exp=0", bus.mdu_stall); end
    bus.ex_hiloren = 2'b01;
    #1;
    checks++; if (bus.hilo_rdata !== exp_lo) begin failures++; $display("FAIL mflo got=%h exp=%h", bus.hilo_rdata, exp_lo); end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_done_hold();
    logic [31:0] a, b;
    logic [63:0] r;
    a = $urandom; b = $urandom;
    r = ref_mul(1'b1, a, b);
    @(posedge clk); #1;
    bus.ex_valid = 1'b1; bus.ex_mult = 1'b1; bus.ex_mdsign = 1'b1; bus.ex_hilowen = 2'b11;
    bus.ex_a = a; bus.ex_b = b; bus.ex_go = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++; if (bus.mdu_stall !== 1'b1) begin failures++; $display("FAIL hold_busy_stall got=%0b exp=1", bus.mdu_stall); end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (bus.mdu_stall !== 1'b0) begin failures++; $display("FAIL hold_stall cyc=%0d got=%0b exp=0", k, bus.mdu_stall); end
      checks++; if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin failures++; $display("FAIL hold_hilo cyc=%0d got=%h_%h exp=%h_%h", k, bus.hi, bus.lo, exp_hi, exp_lo); end
    end
    @(posedge clk); #1;
    bus.ex_go = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    exp_hi = r[63:32]; exp_lo = r[31:0];
    checks++; if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin failures++; $display("FAIL hold_commit got=%h_%h exp=%h_%h", bus.hi, bus.lo, exp_hi, exp_lo); end
    do_mt(2'b01, 32'h5555_AAAA);
    bus.ex_go = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.lo !== exp_lo) begin failures++; $display("FAIL hold_once got=%h exp=%h", bus.lo, exp_lo); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int st;
    logic [63:0] r;
    run_op(1'b1, 1'b0, 1'b0, 32'd40000, 32'd70000, st);
    run_op(1'b0, 1'b1, 1'b0, 32'd1000, 32'd33, st);
    r = ref_div(1'b0, 32'd1000, 32'd33);
    checks++; if (st !== 33) begin failures++; $display("FAIL b2b_stall got=%0d exp=33", st); end
    checks++; if ({bus.hi, bus.lo} !== r) begin failures++; $display("FAIL b2b_res got=%h_%h exp=%h", bus.hi, bus.lo, r); end
    exp_hi = r[63:32]; exp_lo = r[31:0];
  endtask

  task automatic test_random();
    int st;
    logic is_div, sg;
    logic [31:0] a, b;
    logic [63:0] r;
    for (int n = 0; n < 20; n++) begin
      is_div = 1'($urandom_range(0, 1));
      sg     = 1'($urandom_range(0, 1));
      a      = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if (n == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; is_div = 1'b1; sg = 1'b1; end
      r = is_div ? ref_div(sg, a, b) : ref_mul(sg, a, b);
      run_op(1'($urandom_range(0, 1)), is_div, sg, a, b, st);
      checks++; if (st !== (is_div ? 33 : 2)) begin failures++; $display("FAIL rand_stall n=%0d div=%0b got=%0d", n, is_div, st); end
      checks++; if ({bus.hi, bus.lo} !== r) begin failures++; $display("FAIL rand_res n=%0d div=%0b sg=%0b a=%h b=%h got=%h_%h exp=%h", n, is_div, sg, a, b, bus.hi, bus.lo, r); end
      exp_hi = r[63:32]; exp_lo = r[31:0];
    end
  endtask

  task automatic test_reset_mid();
    int st;
    do_mt(2'b11, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    bus.ex_valid = 1'b1; bus.ex_div = 1'b1; bus.ex_hilowen = 2'b11;
    bus.ex_a = 32'h0000_1000; bus.ex_b = 32'd3; bus.ex_go = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (bus.mdu_stall !== 1'b0) begin failures++; $display("FAIL rstmid_stall got=%0b exp=0", bus.mdu_stall); end
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin failures++; $display("FAIL rstmid_hilo got=%h_%h exp=0_0", bus.hi, bus.lo); end
    @(negedge clk);
    idle_inputs();
    resetn = 1'b1;
    run_op(1'b1, 1'b1, 1'b0, 32'd100, 32'd7, st);
    checks++; if (st !== 33) begin failures++; $display("FAIL rstmid_div_stall got=%0d exp=33", st); end
    checks++; if (bus.hi !== 32'd2 || bus.lo !== 32'd14) begin failures++; $display("FAIL rstmid_div_res got=%h_%h exp=00000002_0000000e", bus.hi, bus.lo); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_flush();
    test_mthi_mfhi();
    test_done_hold();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hilo_mdu.md
# hilo_mdu

Multiply/divide unit and HI/LO register file for the EX stage. It consumes the decoder's `mult`, `div`, `mdsign`, `hilowen` and `hiloren` controls and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO. Multi-cycle operations hold EX through a stall output. HI/LO commit only when the owning instruction leaves EX unflushed.

## Interface
- Parameters: none.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `ex_valid` input 1: EX holds a valid instruction.
- `ex_mult` input 1: MULT/MULTU in EX.
- `ex_div` input 1: DIV/DIVU in EX.
- `ex_mdsign` input 1: 1 = signed operation.
- `ex_hilowen` input 2: bit0 = write LO, bit1 = write HI. Equals 2'b11 for mult/div.
- `ex_hiloren` input 2: 2'b01 = read LO, 2'b10 = read HI.
- `ex_a` input 32: GPR[rs]; multiplicand/dividend; MTHI/MTLO data.
- `ex_b` input 32: GPR[rt]; multiplier/divisor.
- `ex_go` input 1: EX would advance this cycle, ignoring this block's stall.
- `flush` input 1: exception/eret flush of EX.
- `mdu_stall` output 1: hold EX this cycle.
- `hilo_rdata` output 32: HI when `ex_hiloren[1]`, else LO.
- `hi`, `lo` output 32 each: architectural HI and LO.

## Operation
- States:
  - IDLE
  - MUL: one cycle.
  - DIV: 32 cycles, 5-bit counter.
  - DONE: result held in 64-bit `res`.
- Start condition: state IDLE, `ex_valid`, (`ex_mult` | `ex_div`), and `!flush`.
  - On start: latch `ex_a`, `ex_b` and the sign flag.
  - Go to MUL or DIV.
- MUL:
  - Register the 64-bit product of the latched operands: signed×signed or unsigned×unsigned.
  - `res` = {HI, LO} = {product[63:32], product[31:0]}.
  - Go to DONE.
- DIV, restoring algorithm on magnitudes:
  - Signed mode uses |a| and |b|; 0x80000000 is treated as 2^31 unsigned.
  - One quotient bit per cycle, MSB first.
  - On the 32nd iteration, apply sign fix-up combinationally and load `res`:
    - Quotient is negated when the operand signs differ.
    - Remainder takes the sign of the dividend.
  - Then go to DONE.
  - HI = remainder, LO = quotient.
- Divide by zero is not special-cased and must not hang. The unsigned result is LO = 0xFFFFFFFF, HI = dividend.
- DONE:
  - If `ex_go & !flush`: commit `res` to HI/LO and go to IDLE.
  - Otherwise hold `res` and remain in DONE.
- `flush` in any state: go to IDLE next cycle with no HI/LO write. `flush` has priority over `ex_go` and over start.
- MTHI/MTLO (no mult/div, `ex_hilowen` != 0):
  - Condition: state IDLE and `ex_valid & ex_go & !flush`.
  - Write `ex_a` to the selected register(s) at the clock edge.
  - No stall.
- Reads are combinational from the architectural HI/LO. A write committed at cycle N is visible to the EX instruction in cycle N+1, so no forwarding is needed.
- `mdu_stall` = start | (state == MUL) | (state == DIV). It is 0 in IDLE (without start) and in DONE.
- Reset (async, `resetn` = 0):
  - state = IDLE, counter = 0.
  - `res`, `hi` and `lo` all 0.
  - `mdu_stall` = 0.
  - A reset mid-operation aborts with no write.

## Timing
- MULT/MULTU:
  - Start cycle T: stall = 1.
  - T+1: MUL, stall = 1.
  - T+2: DONE, stall = 0.
  - HI/LO updated at the end of T+2 if `ex_go`.
  - Two stall cycles total.
- DIV/DIVU:
  - Start cycle T: stall = 1.
  - T+1..T+32: DIV, stall = 1.
  - T+33: DONE, stall = 0.
  - 33 stall cycles total.
- DONE with `ex_go` = 0 (downstream stall): result held and no restart. The next start is accepted only after return to IDLE.
- Back-to-back mult/div: the second instruction's start is at the earliest one cycle after the first's commit edge.
- Flush in the start cycle: no state change. Flush in MUL/DIV/DONE: IDLE on the next edge, and `mdu_stall` is 0 in the following cycle.

## Test plan
- MULT with a = 0xFFFFFFFE, b = 3, `ex_go` = 1 → stall exactly 2 cycles, then HI = 0xFFFFFFFF and LO = 0xFFFFFFFA. Same operands as MULTU → HI = 0x00000002, LO = 0xFFFFFFFA.
- DIVU 100/7 → stall exactly 33 cycles, then LO = 14, HI = 2. DIV 0xFFFFFFF9 / 2 (−7/2) → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 0x12345678 / 0 → completes in 33 stall cycles with LO = 0xFFFFFFFF, HI = 0x12345678.
- Start DIV with HI/LO = 0x11/0x22 and assert `flush` on the 10th DIV cycle → HI/LO unchanged, stall 0 the next cycle, and a following MULT 2×3 yields LO = 6 with 2 stall cycles.
- MTHI a = 0xA, then MFHI in the next cycle → `hilo_rdata` = 0x0000000A. MULT reaching DONE with `ex_go` = 0 for 3 cycles → HI/LO unchanged and stall 0 until `ex_go`, then committed once.
- Assert `resetn` = 0 mid-DIV → immediately stall = 0 and HI = LO = 0, and the unit accepts a new DIVU after release.
